// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the FSM state encoding, the reset PC and NOP defaults and the PC
// increment. Decode and the testbench import the same package so the
// constants stay consistent across the pipeline.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INCR   = 32'd4;

  // A redirect target is usable only if it is word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: valid/ready request channel plus a valid-only
// response channel.
//   master (fetch side): drives imem_req_valid, imem_addr;
//                        receives imem_req_ready, imem_rsp_valid, imem_rdata.
//   slave (memory side): the mirror image.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register.
// Ports: clk, reset (async, active-high, loads INIT), load (enable),
//        d (next PC), q (current PC).
// The choice of next PC is made by the fetch stage; this block only stores it.
module pc_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] INIT = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= INIT;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one request at a time to instruction
// memory, holds the returned word with its PC and PC+4 for decode, follows
// redirects from execute and waits while downstream stalls.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   imem                  instruction memory bus (master side)
//   redirect_valid/target branch or jump from execute (one-cycle pulse)
//   stall                 downstream cannot take the held instruction
//   instr_valid, instr, instr_pc, instr_pc_plus4   held instruction
//   fetch_fault           sticky: a misaligned redirect target was seen
// All outputs come straight from registers.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_if.master        imem,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_target,
  input  logic                       stall,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  output logic [31:0]                instr_pc_plus4,
  output logic                       fetch_fault
);

  fetch_state_t state_reg, state_next;

  logic        discard_reg, discard_next;
  logic        fault_reg, fault_next;
  logic        req_valid_reg, req_valid_next;
  logic        instr_valid_reg, instr_valid_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic [31:0] plus4_reg, plus4_next;

  logic [31:0] pc;
  logic        pc_load;
  logic [31:0] pc_d;

  // Once a fault is pending (draining the last response) further redirects
  // are meaningless and are ignored.
  logic redir_ok, redir_bad;
  assign redir_ok  = redirect_valid && is_aligned(redirect_target) && !fault_reg;
  assign redir_bad = redirect_valid && !is_aligned(redirect_target) && !fault_reg;

  pc_register #(.INIT(BOOT_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_REQ;
      ST_REQ: begin
        if (redir_bad) begin
          state_next = ST_FAULT;
        end else if (imem.imem_req_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Without a response we stay here, even with a bad redirect: the
        // outstanding word has to drain before the fetch unit goes quiet.
        if (imem.imem_rsp_valid) begin
          if (fault_reg || redir_bad) begin
            state_next = ST_FAULT;
          end else if (discard_reg || redir_ok) begin
            state_next = ST_REQ;
          end else begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redir_bad) begin
          state_next = ST_FAULT;
        end else if (redir_ok || !stall) begin
          state_next = ST_REQ;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_BOOT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    discard_next     = discard_reg;
    fault_next       = fault_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    plus4_next       = plus4_reg;
    pc_load          = 1'b0;
    pc_d             = pc + PC_INCR;

    case (state_reg)
      ST_REQ: begin
        if (redir_bad) begin
          fault_next = 1'b1;
        end else begin
          if (redir_ok) begin
            pc_load = 1'b1;
            pc_d    = redirect_target;
          end
          // An accepted request in the redirect cycle used the old address,
          // so its word must be thrown away.
          if (imem.imem_req_ready) begin
            discard_next = redir_ok;
          end
        end
      end
      ST_WAIT: begin
        if (redir_bad) begin
          fault_next   = 1'b1;
          discard_next = 1'b1;
        end else if (redir_ok) begin
          pc_load      = 1'b1;
          pc_d         = redirect_target;
          discard_next = 1'b1;
        end
        if (imem.imem_rsp_valid && !discard_reg && !fault_reg && !redir_ok && !redir_bad) begin
          instr_valid_next = 1'b1;
          instr_next       = imem.imem_rdata;
          instr_pc_next    = pc;
          plus4_next       = pc + PC_INCR;
        end
      end
      ST_HOLD: begin
        if (redir_bad) begin
          fault_next       = 1'b1;
          instr_valid_next = 1'b0;
          instr_next       = NOP_INSTR;
        end else if (redir_ok) begin
          // Redirect wins over stall: the held instruction is squashed.
          pc_load          = 1'b1;
          pc_d             = redirect_target;
          instr_valid_next = 1'b0;
          instr_next       = NOP_INSTR;
        end else if (!stall) begin
          pc_load          = 1'b1;
          instr_valid_next = 1'b0;
          instr_next       = NOP_INSTR;
        end
      end
      default: begin
      end
    endcase

    req_valid_next = (state_next == ST_REQ);
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard_reg     <= 1'b0;
      fault_reg       <= 1'b0;
      req_valid_reg   <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= NOP_INSTR;
      instr_pc_reg    <= BOOT_PC;
      plus4_reg       <= BOOT_PC + PC_INCR;
    end else begin
      discard_reg     <= discard_next;
      fault_reg       <= fault_next;
      req_valid_reg   <= req_valid_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      plus4_reg       <= plus4_next;
    end
  end

  assign imem.imem_req_valid = req_valid_reg;
  assign imem.imem_addr      = pc;
  assign instr_valid         = instr_valid_reg;
  assign instr               = instr_reg;
  assign instr_pc            = instr_pc_reg;
  assign instr_pc_plus4      = plus4_reg;
  assign fetch_fault         = fault_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch. Instance 0 runs from the default reset PC
// under directed stimulus; instance 1 boots at 32'hFFFF_FFFC to observe wrap.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        stall = 1'b0;
  logic        ready0 = 1'b1;

  logic        rv[2];
  logic [31:0] addr[2];
  logic        rdy[2];
  logic        ivalid[2];
  logic [31:0] ins[2];
  logic [31:0] ipc[2];
  logic [31:0] ipc4[2];
  logic        flt[2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Memory content: every word is a fixed function of its address.
  function automatic logic [31:0] fword(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      instruction_fetch_if bus ();
      logic        pend = 1'b0;
      logic [31:0] pend_addr = 32'h0;
      logic        rsp_v = 1'b0;
      logic [31:0] rsp_d = 32'h0;

      assign rdy[gi] = (gi == 0) ? ready0 : 1'b1;
      assign bus.imem_req_ready = rdy[gi];
      assign bus.imem_rsp_valid = rsp_v;
      assign bus.imem_rdata     = rsp_d;

      // Two-cycle latency memory; it is not reset, so an in-flight word
      // survives a DUT reset.
      always @(posedge clk) begin
        rsp_v <= pend;
        rsp_d <= fword(pend_addr);
        pend  <= bus.imem_req_valid && bus.imem_req_ready;
        if (bus.imem_req_valid && bus.imem_req_ready) pend_addr <= bus.imem_addr;
      end

      instruction_fetch #(.BOOT_PC((gi == 0) ? RESET_PC : 32'hFFFF_FFFC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem            (bus),
        .redirect_valid  ((gi == 0) ? redirect_valid : 1'b0),
        .redirect_target (redirect_target),
        .stall           ((gi == 0) ? stall : 1'b0),
        .instr_valid     (ivalid[gi]),
        .instr           (ins[gi]),
        .instr_pc        (ipc[gi]),
        .instr_pc_plus4  (ipc4[gi]),
        .fetch_fault     (flt[gi])
      );

      assign rv[gi]   = bus.imem_req_valid;
      assign addr[gi] = bus.imem_addr;
    end
  endgenerate

  // Behavioural model of instance 0: the next instruction to be delivered is
  // the sequential successor of the last one, or the latest aligned redirect.
  logic [31:0] exp_pc = RESET_PC;
  logic        exp_fault = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_instr = 32'h0;

  always @(negedge clk) begin
    if (reset) begin
      exp_pc = RESET_PC;
      exp_fault = 1'b0;
      prev_valid = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("fault_flag", {31'b0, flt[0]}, {31'b0, exp_fault});
      if (exp_fault) begin
        chk("fault_no_req", {31'b0, rv[0]}, 32'd0);
        chk("fault_no_valid", {31'b0, ivalid[0]}, 32'd0);
      end
      if (!ivalid[0]) begin
        chk("idle_nop", ins[0], NOP_INSTR);
      end else begin
        chk("instr_word", ins[0], fword(ipc[0]));
        chk("pc_plus4", ipc4[0], ipc[0] + 32'd4);
        chk("no_req_while_held", {31'b0, rv[0]}, 32'd0);
        if (!prev_valid) begin
          chk("instr_pc", ipc[0], exp_pc);
          exp_pc = exp_pc + 32'd4;
        end else begin
          chk("held_only_when_stalled", {31'b0, prev_hold}, 32'd1);
          chk("stable_pc", ipc[0], prev_pc);
          chk("stable_instr", ins[0], prev_instr);
        end
      end
      if (rv[0] && rdy[0] && !redirect_valid) chk("fetch_addr", addr[0], exp_pc);
      prev_valid = ivalid[0];
      prev_hold  = stall && !redirect_valid;
      prev_pc    = ipc[0];
      prev_instr = ins[0];
      if (redirect_valid && !exp_fault) begin
        if (redirect_target[1:0] == 2'b00) exp_pc = redirect_target;
        else exp_fault = 1'b1;
      end
    end
  end

  // Instance 1: record first two request addresses and first delivered word.
  logic [31:0] acc1[2];
  int          n_acc1 = 0;
  logic        got1 = 1'b0;
  logic [31:0] first_pc1 = 32'h0;
  logic [31:0] first_p4_1 = 32'h0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rv[1] && n_acc1 < 2) begin
        acc1[n_acc1] = addr[1];
        n_acc1++;
      end
      if (ivalid[1] && !got1) begin
        got1 = 1'b1;
        first_pc1 = ipc[1];
        first_p4_1 = ipc4[1];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    tick();
    while (!ivalid[0] && n < 40) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'b0, ivalid[0]}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values, applied asynchronously before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_req_valid", {31'b0, rv[0]}, 32'd0);
    chk("rst_addr", addr[0], 32'h0040_0000);
    chk("rst_instr_valid", {31'b0, ivalid[0]}, 32'd0);
    chk("rst_instr", ins[0], 32'h0000_0013);
    chk("rst_instr_pc", ipc[0], 32'h0040_0000);
    chk("rst_pc_plus4", ipc4[0], 32'h0040_0004);
    chk("rst_fault", {31'b0, flt[0]}, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Sequential fetch, 2-cycle memory
    tick();
    chk("boot_req_cycle1", {31'b0, rv[0]}, 32'd1);
    chk("boot_addr", addr[0], 32'h0040_0000);
    tick();
    tick();
    chk("latency_not_yet", {31'b0, ivalid[0]}, 32'd0);
    tick();
    chk("latency_valid", {31'b0, ivalid[0]}, 32'd1);
    chk("first_pc", ipc[0], 32'h0040_0000);
    chk("first_instr", ins[0], 32'h1317_9BDF);
    chk("first_plus4", ipc4[0], 32'h0040_0004);
    wait_valid();
    chk("second_pc", ipc[0], 32'h0040_0004);
    chk("second_instr", ins[0], 32'h1317_9BDB);
    wait_valid();
    chk("third_pc", ipc[0], 32'h0040_0008);
    chk("third_instr", ins[0], 32'h1317_9BD7);

    // Stall for 5 cycles while holding
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_req", {31'b0, rv[0]}, 32'd0);
      chk("stall_pc", ipc[0], 32'h0040_0008);
    end
    stall = 1'b0;
    tick();
    chk("after_stall_valid", {31'b0, ivalid[0]}, 32'd0);
    chk("after_stall_req", {31'b0, rv[0]}, 32'd1);
    chk("after_stall_addr", addr[0], 32'h0040_000C);

    // Redirect during WAIT: in-flight word must be dropped
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0100;
    tick();
    redirect_valid = 1'b0;
    wait_valid();
    chk("redir_wait_pc", ipc[0], 32'h0040_0100);
    chk("redir_wait_instr", ins[0], 32'h1317_9ADF);

    // Redirect in HOLD takes priority over stall
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0200;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk("redir_hold_valid", {31'b0, ivalid[0]}, 32'd0);
    chk("redir_hold_addr", addr[0], 32'h0040_0200);

    // Redirect in REQ while memory is not ready: address moves under valid
    ready0 = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0300;
    tick();
    redirect_valid = 1'b0;
    chk("redir_req_valid", {31'b0, rv[0]}, 32'd1);
    chk("redir_req_addr", addr[0], 32'h0040_0300);
    ready0 = 1'b1;
    wait_valid();
    chk("redir_req_pc", ipc[0], 32'h0040_0300);

    // Misaligned redirect during WAIT
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0102;
    tick();
    redirect_valid = 1'b0;
    chk("fault_set", {31'b0, flt[0]}, 32'd1);
    repeat (10) tick();
    chk("fault_sticky", {31'b0, flt[0]}, 32'd1);
    chk("fault_quiet_req", {31'b0, rv[0]}, 32'd0);
    chk("fault_quiet_valid", {31'b0, ivalid[0]}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("fault_cleared", {31'b0, flt[0]}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Async reset mid-WAIT, stale response delivered afterwards
    tick();
    tick();
    chk("stale_in_wait", {31'b0, rv[0]}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_addr", addr[0], 32'h0040_0000);
    chk("mid_rst_req", {31'b0, rv[0]}, 32'd0);
    #4 reset = 1'b0;
    wait_valid();
    chk("post_rst_pc", ipc[0], 32'h0040_0000);
    chk("post_rst_instr", ins[0], 32'h1317_9BDF);

    // Wrap-around instance
    chk("wrap_seen", {31'b0, got1}, 32'd1);
    chk("wrap_req_count", (n_acc1 >= 2) ? 32'd1 : 32'd0, 32'd1);
    chk("wrap_addr0", acc1[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", acc1[1], 32'h0000_0000);
    chk("wrap_first_pc", first_pc1, 32'hFFFF_FFFC);
    chk("wrap_plus4", first_p4_1, 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetches one 32-bit RISC-V instruction at a time from instruction memory over a valid/ready request and valid-only response interface. It holds the instruction, its PC and PC+4 in output registers for decode and the immediate sign-extension stage. It accepts branch and jump redirects from execute, and it stalls while downstream is busy. It sits directly upstream of decode and the immediate generator in the RISC-V processor.

## Interface
- RESET_PC, 32'h0040_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: value of `instr` whenever no valid instruction is held (addi x0,x0,0).
- clk  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high.
- imem_req_valid  out  1  request to memory; registered.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  fetch address; always equals `pc`.
- imem_rsp_valid  in  1  read data valid; arrives at least 1 cycle after the accepting cycle.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse from execute: take branch or jump.
- redirect_target  in  32  new PC.
- stall  in  1  downstream cannot consume `instr` this cycle.
- instr_valid  out  1  `instr`, `instr_pc` and `instr_pc_plus4` are valid.
- instr  out  32  held instruction.
- instr_pc  out  32  address of `instr`.
- instr_pc_plus4  out  32  `instr_pc` + 4, modulo 2^32.
- fetch_fault  out  1  sticky; set by a misaligned redirect target.

## Operation
- FSM states: BOOT, REQ, WAIT, HOLD, FAULT.
- BOOT (reset state) moves to REQ on the next clock.
- REQ: `imem_req_valid`=1. When `imem_req_ready`=1, move to WAIT and clear `discard`.
- WAIT: when `imem_rsp_valid`=1:
  - If `discard`=0, capture `instr`/`instr_pc`/`instr_pc_plus4`, set `instr_valid`=1 and move to HOLD.
  - Otherwise drop the word and move to REQ.
- HOLD: when `stall`=0, set `pc` to `pc`+4, clear `instr_valid`, set `instr` to NOP_INSTR and move to REQ.
- Redirect with `redirect_target[1:0]`==0:
  - `pc` takes `redirect_target` in every state except BOOT and FAULT.
  - HOLD: clear `instr_valid` and move to REQ; redirect has priority over `stall`.
  - WAIT: set `discard`=1. If a response arrives in the same cycle, drop it and move to REQ.
  - REQ with `imem_req_ready`=1: the request goes out to the old address; set `discard`=1 and move to WAIT.
  - REQ with `imem_req_ready`=0: the address changes while valid is high. This interface permits address change while not accepted.
- Redirect with a misaligned target (low bits non-zero): set `fetch_fault`, clear `instr_valid`, set `instr` to NOP_INSTR. Move to FAULT; if in WAIT, first drain the outstanding response.
- FAULT: no requests are issued. Only reset leaves FAULT.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- At most one request is outstanding. `imem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_addr`=RESET_PC.
  - `instr_valid`=0, `instr`=NOP_INSTR.
  - `instr_pc`=RESET_PC, `instr_pc_plus4`=RESET_PC+4.
  - `fetch_fault`=0, `discard`=0, state BOOT.
- After reset deasserts: edge 1 moves to REQ, so `imem_req_valid` is high from cycle 1.
- Fetch latency: accept at cycle N, response at cycle M (M ≥ N+1), `instr_valid` high from cycle M+1.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation returns everything to reset values immediately. A response arriving after reset is ignored because the state is not WAIT.

## Structure
- Shared package:
  - FSM state encoding (3 bits).
  - RESET_PC and NOP_INSTR defaults.
  - PC_INCR constant = 4.
  - These are reused by decode and the testbench.
- Sub-module `pc_register`: 32-bit register with asynchronous active-high reset to RESET_PC and a load-enable. The next-PC mux (pc+4 / redirect) stays in `instruction_fetch`.

## Test plan
- Memory with 2-cycle latency and ready always 1; stall=0. Required: after reset, instructions at 0x0040_0000, 0x0040_0004 and 0x0040_0008 appear with correct `instr_pc`, each `instr_valid` pulse lasts 1 cycle, and `instr_pc_plus4` = `instr_pc`+4.
- Hold `stall`=1 for 5 cycles while in HOLD. Required: `instr` and `instr_pc` stay stable, and no new request is issued until `stall` drops.
- Pulse `redirect_valid`, target 0x0040_0100, during WAIT. Required: the in-flight word is discarded, the next `instr_valid` shows `instr_pc`=0x0040_0100, and no instruction from the old stream appears.
- Pulse `redirect_valid`, target 0x0040_0102. Required: `fetch_fault`=1, `instr_valid`=0 and `imem_req_valid`=0 permanently; asserting reset clears the fault.
- Start with RESET_PC=32'hFFFF_FFFC. Required: the second fetch address is 32'h0000_0000.
- Assert reset asynchronously mid-WAIT, then deliver the stale response after release. Required: it is ignored, and the first valid `instr_pc` is RESET_PC.
